// File: rtl/serial_tx_param.sv
// -----------------------------------------------------------------------------
// serial_tx_param
//
// Parametrised framed serial transmitter with a small input FIFO.
// Parallel words are queued by an active-low load strobe (one word per falling
// edge of load_n). Each word is sent as a frame:
//   start bit (0), DATA_W data bits LSB-first, [parity bit], STOP_BITS stop bits (1).
// Every bit is held for BIT_TICKS clocks.
//
// Optional feature macro: SERIAL_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the data bits) follows the data bits.
//
// Parameters:
//   DATA_W     data bits per character (5..16)
//   BIT_TICKS  clocks per serial bit (>=2)
//   STOP_BITS  stop bits per frame (1 or 2)
//   FIFO_DEPTH buffered words (power of two, >=2)
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   t_enable   allows new frames to start (sampled in IDLE and at frame end)
//   data_in    word to enqueue
//   load_n     active-low load strobe
//   data_out   serial line, idles high
//   charSent   one-cycle pulse during the last clock of each frame
//   busy       high while a frame is in progress
//   full       FIFO full
//   overflow   sticky flag: a load was dropped because the FIFO was full
//   fifo_count number of buffered words
// -----------------------------------------------------------------------------
module serial_tx_param #(
   parameter int DATA_W     = 8,
   parameter int BIT_TICKS  = 16,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          t_enable,
   input  logic [DATA_W-1:0]             data_in,
   input  logic                          load_n,
   output logic                          data_out,
   output logic                          charSent,
   output logic                          busy,
   output logic                          full,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(BIT_TICKS);
   localparam int BW = $clog2(DATA_W);

   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] TICK_PRE  = TW'(BIT_TICKS - 2);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef SERIAL_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t              state;
   logic [TW-1:0]       tick;
   logic [BW-1:0]       bit_cnt;     // data bit index, reused as stop bit index
   logic [DATA_W-1:0]   shreg;
`ifdef SERIAL_TX_PARITY_EN
   logic                par_bit;
`endif

   logic                load_prev;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [DATA_W-1:0]   head;

   logic                wr_req;
   logic                wr_ok;
   logic                frame_end;
   logic                pop;
   logic [CW-1:0]       count_next;

   // Falling edge of load_n against its registered history.
   assign wr_req    = !load_n && load_prev;
   assign wr_ok     = wr_req && !full;
   assign head      = mem[rd_ptr];
   assign frame_end = (state == STOP) && (tick == TICK_LAST) && (bit_cnt == STOP_LAST);
   // A new word is taken either from idle or straight at the end of a frame,
   // which gives back-to-back frames without an idle gap.
   assign pop       = t_enable && (fifo_count != '0) && ((state == IDLE) || frame_end);

   always_comb begin
      count_next = fifo_count;
      if (wr_ok && !pop) begin
         count_next = fifo_count + 1'b1;
      end else if (!wr_ok && pop) begin
         count_next = fifo_count - 1'b1;
      end
   end

   // FIFO storage: data only, no reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // FIFO control and load strobe history.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_prev  <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         full       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         load_prev  <= load_n;
         fifo_count <= count_next;
         full       <= (count_next == DEPTH_C);
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (wr_req && full) begin
            overflow <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Frame state machine; all line outputs are registered here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         tick     <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
`ifdef SERIAL_TX_PARITY_EN
         par_bit  <= 1'b0;
`endif
         data_out <= 1'b1;
         charSent <= 1'b0;
         busy     <= 1'b0;
      end else begin
         charSent <= 1'b0;

         if (state != IDLE) begin
            tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
         end

         case (state)
            IDLE: begin
               data_out <= 1'b1;
               busy     <= 1'b0;
               tick     <= '0;
               if (pop) begin
                  shreg    <= head;
`ifdef SERIAL_TX_PARITY_EN
                  par_bit  <= ^head;
`endif
                  state    <= START;
                  data_out <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            START: begin
               if (tick == TICK_LAST) begin
                  state    <= DATA;
                  bit_cnt  <= '0;
                  data_out <= shreg[0];
               end
            end

            DATA: begin
               if (tick == TICK_LAST) begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt  <= '0;
`ifdef SERIAL_TX_PARITY_EN
                     state    <= PARITY;
                     data_out <= par_bit;
`else
                     state    <= STOP;
                     data_out <= 1'b1;
`endif
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     shreg    <= shreg >> 1;
                     data_out <= shreg[1];
                  end
               end
            end

`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
               if (tick == TICK_LAST) begin
                  state    <= STOP;
                  bit_cnt  <= '0;
                  data_out <= 1'b1;
               end
            end
`endif

            STOP: begin
               // Raise charSent one clock early so the registered pulse
               // lines up with the final clock of the frame.
               if ((tick == TICK_PRE) && (bit_cnt == STOP_LAST)) begin
                  charSent <= 1'b1;
               end
               if (tick == TICK_LAST) begin
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     if (pop) begin
                        shreg    <= head;
`ifdef SERIAL_TX_PARITY_EN
                        par_bit  <= ^head;
`endif
                        state    <= START;
                        data_out <= 1'b0;
                     end else begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               data_out <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_param.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_param
//
// Self-checking bench for serial_tx_param with default parameters. A
// frame-level reference model (word queue + elapsed-clock position within the
// frame) predicts every output each cycle; directed sequences plus randomized
// loads exercise the design. Define SERIAL_TX_PARITY_EN to check the parity
// build.
// -----------------------------------------------------------------------------
module tb_serial_tx_param;

   localparam int DW = 8;
   localparam int BT = 16;
   localparam int SB = 1;
   localparam int FD = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME = (1 + DW + SB + PAR) * BT;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          t_enable;
   logic [DW-1:0] data_in;
   logic          load_n;
   logic          data_out;
   logic          charSent;
   logic          busy;
   logic          full;
   logic          overflow;
   logic [$clog2(FD):0] fifo_count;

   serial_tx_param #(
      .DATA_W(DW), .BIT_TICKS(BT), .STOP_BITS(SB), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset_n(reset_n), .t_enable(t_enable), .data_in(data_in),
      .load_n(load_n), .data_out(data_out), .charSent(charSent), .busy(busy),
      .full(full), .overflow(overflow), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] mq[$];
   bit            m_act;
   int            m_el;
   logic [DW-1:0] m_word;
   bit            m_prev;
   bit            m_ovf;

   function automatic void m_reset();
      mq.delete();
      m_act  = 1'b0;
      m_el   = 0;
      m_prev = 1'b1;
      m_ovf  = 1'b0;
      m_word = '0;
   endfunction

   // Expected line level from the position inside the current frame.
   function automatic logic m_line();
      int p;
      if (!m_act) return 1'b1;
      p = m_el / BT;
      if (p == 0) return 1'b0;
      if (p <= DW) return m_word[p-1];
      if (PAR == 1 && p == DW + 1) return ^m_word;
      return 1'b1;
   endfunction

   always @(posedge clk) begin : model_step
      int old_sz;
      if (!reset_n) begin
         m_reset();
      end else begin
         old_sz = mq.size();
         if (m_act && m_el != FRAME - 1) begin
            m_el++;
         end else if (t_enable && old_sz > 0) begin
            m_word = mq.pop_front();
            m_act  = 1'b1;
            m_el   = 0;
         end else begin
            m_act = 1'b0;
         end
         if (!load_n && m_prev) begin
            if (old_sz == FD) m_ovf = 1'b1;
            else mq.push_back(data_in);
         end
         m_prev = load_n;
      end
   end

   // ---------------- per-cycle comparison ----------------
   bit chk_en   = 1'b0;
   int sent_cnt = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("data_out",   data_out,   m_line());
         chk("busy",       busy,       m_act);
         chk("charSent",   charSent,   (m_act && m_el == FRAME - 1));
         chk("fifo_count", fifo_count, mq.size());
         chk("full",       full,       (mq.size() == FD));
         chk("overflow",   overflow,   m_ovf);
         if (charSent) sent_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic strobe(input logic [DW-1:0] d, input int low_cycles);
      @(negedge clk);
      data_in = d;
      load_n  = 1'b0;
      repeat (low_cycles) @(negedge clk);
      load_n  = 1'b1;
   endtask

   task automatic wait_idle(input int limit);
      int k;
      k = 0;
      while ((m_act || mq.size() != 0) && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", (k < limit), 1);
      chk("idle_busy", busy, 0);
   endtask

`ifdef SERIAL_TX_PARITY_EN
   int t1_exp[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
   int t1_exp[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int k;
      reset_n  = 1'b1;
      t_enable = 1'b0;
      load_n   = 1'b1;
      data_in  = '0;
      m_reset();
      #1 reset_n = 1'b0;
      #1;
      chk("rst_data_out",   data_out,   1);
      chk("rst_busy",       busy,       0);
      chk("rst_charSent",   charSent,   0);
      chk("rst_full",       full,       0);
      chk("rst_overflow",   overflow,   0);
      chk("rst_fifo_count", fifo_count, 0);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Single A5 frame: bit levels sampled mid-bit
      t_enable = 1'b1;
      @(negedge clk);
      data_in = 8'hA5;
      load_n  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      load_n = 1'b1;
      @(posedge clk);
      for (int i = 0; i < $size(t1_exp); i++) begin
         repeat (8) @(posedge clk);
         #1 chk("t1_bit", data_out, t1_exp[i]);
         repeat (8) @(posedge clk);
      end
      wait_idle(400);

      // Back-to-back frames
      base = sent_cnt;
      strobe(8'h00, 1);
      strobe(8'hFF, 1);
      strobe(8'h3C, 1);
      wait_idle(FRAME * 4);
      chk("t2_frames", sent_cnt - base, 3);

      // Long load strobe queues one word
      t_enable = 1'b0;
      strobe(8'h5A, 100);
      chk("t4_count", fifo_count, 1);
      t_enable = 1'b1;
      wait_idle(FRAME * 2);

      // Fill, overflow, drain
      t_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         strobe(8'(i * 37 + 3), 1);
         if (i == 3) begin
            chk("t3_full",  full,       1);
            chk("t3_count", fifo_count, 4);
         end
      end
      chk("t3_overflow", overflow,   1);
      chk("t3_count5",   fifo_count, 4);
      base = sent_cnt;
      t_enable = 1'b1;
      wait_idle(FRAME * 6);
      chk("t3_frames",      sent_cnt - base, 4);
      chk("t3_ovf_sticky",  overflow,        1);

      // Asynchronous reset mid-DATA with two words queued
      t_enable = 1'b0;
      strobe(8'h11, 1);
      strobe(8'h22, 1);
      strobe(8'h33, 1);
      t_enable = 1'b1;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!(m_act && m_el == 3 * BT + 5) && k < 2000);
      chk("t5_reached", (k < 2000), 1);
      chk("t5_queued", fifo_count, 2);
      #1 reset_n = 1'b0;
      m_reset();
      #1;
      chk("t5_data_out",   data_out,   1);
      chk("t5_busy",       busy,       0);
      chk("t5_fifo_count", fifo_count, 0);
      chk("t5_overflow",   overflow,   0);
      base = sent_cnt;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("t5_no_char", sent_cnt - base, 0);

      // Randomized loads and t_enable toggling
      for (int i = 0; i < 60; i++) begin
         t_enable = ($urandom_range(0, 3) != 0);
         strobe(8'($urandom), $urandom_range(1, 4));
         repeat ($urandom_range(0, 120)) @(negedge clk);
      end
      t_enable = 1'b1;
      wait_idle(FRAME * (FD + 2));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
